// File: rtl/spi_txn_scheduler.sv
// Two-requester scheduler in front of a byte-level SPI master: round-robin grant, framed multi-byte bursts.
// Optional busy watchdog compiled in with `define SPI_SCHED_TIMEOUT_EN.
module spi_txn_scheduler #(
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned CS_GAP      = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [7:0]       tx0,
  input  logic [7:0]       tx1,
  output logic [1:0]       tx_ack,
  output logic [7:0]       rx_data,
  output logic [1:0]       rx_valid,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic [1:0]       gnt,
  output logic             cs_n,
  output logic             spi_en_n,
  output logic [7:0]       spi_tx,
  input  logic [7:0]       spi_rx,
  input  logic             spi_busy
);

  typedef enum logic [3:0] {
    IDLE, GRANT, LOAD, START, WAIT_HI, WAIT_LO, CAPTURE, GAP, FINISH
  } state_t;

  if (CS_GAP < 1 || CS_GAP > 15 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("spi_txn_scheduler: CS_GAP or TIMEOUT_CYC out of range");
  end

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_owner;
  logic             r_last;
  logic [LEN_W-1:0] r_rem;
  logic [3:0]       r_gap;
  logic [7:0]       r_spi_tx;
  logic [7:0]       r_rx_data;
  logic [1:0]       w_win;
  logic             w_wait;
  logic             w_timeout;

  assign w_wait  = (r_state == WAIT_HI) || (r_state == WAIT_LO);
  assign spi_tx  = r_spi_tx;
  assign rx_data = r_rx_data;

  // On contention the requester not named by r_last wins.
  always_comb begin
    w_win = req;
    if (req == 2'b11) w_win = r_last ? 2'b01 : 2'b10;
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] r_wd;
  logic [1:0]      r_err;

  always_ff @(posedge sclk) begin
    if (!rst) begin
      r_wd  <= '0;
      r_err <= '0;
    end else begin
      r_err <= '0;
      if (r_state == START) r_wd <= '0;
      else if (w_wait)      r_wd <= r_wd + WD_W'(1);
      if (w_timeout)        r_err <= r_owner;
    end
  end

  assign w_timeout = w_wait && (r_wd == WD_W'(TIMEOUT_CYC - 1));
  assign err       = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = '0;
`endif

  always_ff @(posedge sclk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_last    <= 1'b1;
      r_rem     <= '0;
      r_gap     <= '0;
      r_spi_tx  <= '0;
      r_rx_data <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE:    if (|req) r_owner <= w_win;
        GRANT: begin
          r_rem  <= r_owner[1] ? len1 : len0;
          r_last <= r_owner[1];
        end
        LOAD:    r_spi_tx <= r_owner[1] ? tx1 : tx0;
        WAIT_LO: if (!spi_busy && !w_timeout) r_rx_data <= spi_rx;
        CAPTURE: begin
          if (r_rem != '0) r_rem <= r_rem - LEN_W'(1);
          r_gap <= '0;
        end
        GAP:     r_gap <= r_gap + 4'(1);
        default: ;
      endcase
    end
  end

  // gnt and done both come from r_owner so done can pulse after gnt has dropped.
  always_comb begin
    w_next   = r_state;
    gnt      = '0;
    cs_n     = 1'b1;
    spi_en_n = 1'b1;
    tx_ack   = '0;
    rx_valid = '0;
    done     = '0;
    if (r_state != IDLE && r_state != FINISH) begin
      gnt  = r_owner;
      cs_n = 1'b0;
    end
    case (r_state)
      IDLE:    if (|req) w_next = GRANT;
      GRANT:   w_next = LOAD;
      LOAD: begin
        tx_ack = r_owner;
        w_next = START;
      end
      START: begin
        spi_en_n = 1'b0;
        w_next   = WAIT_HI;
      end
      WAIT_HI: begin
        if (w_timeout)     w_next = IDLE;
        else if (spi_busy) w_next = WAIT_LO;
      end
      WAIT_LO: begin
        if (w_timeout)      w_next = IDLE;
        else if (!spi_busy) w_next = CAPTURE;
      end
      CAPTURE: begin
        rx_valid = r_owner;
        w_next   = (r_rem == '0) ? FINISH : GAP;
      end
      GAP:     if (r_gap == 4'(CS_GAP - 1)) w_next = LOAD;
      FINISH: begin
        done   = r_owner;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler with a behavioural SPI master (20-cycle echo) and requester byte feeders.
// Honours `define SPI_SCHED_TIMEOUT_EN to pick the watchdog or the wait-forever expectation.
module tb_spi_txn_scheduler;

  logic       sclk;
  logic       rst;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic [7:0] tx0, tx1;
  logic [1:0] tx_ack, rx_valid, done, err, gnt;
  logic [7:0] rx_data, spi_tx, spi_rx;
  logic       cs_n, spi_en_n, spi_busy;

  spi_txn_scheduler #(.LEN_W(4), .CS_GAP(2), .TIMEOUT_CYC(64)) dut (
    .sclk(sclk), .rst(rst), .req(req), .len0(len0), .len1(len1),
    .tx0(tx0), .tx1(tx1), .tx_ack(tx_ack), .rx_data(rx_data),
    .rx_valid(rx_valid), .done(done), .err(err), .gnt(gnt), .cs_n(cs_n),
    .spi_en_n(spi_en_n), .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_busy(spi_busy)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_chk = 0;
  int n_err = 0;

  int cyc_n = 0, t0 = 0;
  int n_ack, n_rxv, n_done, n_errp, n_gnt, n_cs_low, n_cs_bad, n_multi;
  int done_cyc, err_cyc;
  logic [1:0] done_who, done_gnt, err_who, err_gnt, prev_gnt;
  logic       done_csn, err_csn;
  logic [7:0] rx_log [16];
  logic [1:0] rxv_who [16];
  logic [1:0] gnt_seq [16];
  int         gnt_cyc [16];
  logic [7:0] b0 [8];
  logic [7:0] b1 [8];
  int         i0, i1;
  logic [1:0] ack_d;
  logic       auto_drop;
  int         m_cnt;
  logic       m_hang;
  logic [7:0] m_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_ack = 0; n_rxv = 0; n_done = 0; n_errp = 0; n_gnt = 0;
    n_cs_low = 0; n_cs_bad = 0; n_multi = 0;
    done_cyc = -1; err_cyc = -1;
    i0 = 0; i1 = 0; ack_d = '0;
    tx0 = b0[0]; tx1 = b1[0];
    t0 = cyc_n;
  endtask

  // One cycle: sample at negedge, then update the requester and master models.
  task automatic cyc();
    @(negedge sclk);
    cyc_n++;
    if ($countones(tx_ack) > 1 || $countones(rx_valid) > 1 ||
        $countones(done) > 1 || $countones(err) > 1 || $countones(gnt) > 1) n_multi++;
    if (tx_ack != 0) n_ack++;
    if (rx_valid != 0) begin
      rx_log[n_rxv & 15] = rx_data;
      rxv_who[n_rxv & 15] = rx_valid;
      n_rxv++;
    end
    if (done != 0) begin
      n_done++; done_cyc = cyc_n - t0; done_who = done; done_gnt = gnt; done_csn = cs_n;
    end
    if (err != 0) begin
      n_errp++; err_cyc = cyc_n - t0; err_who = err; err_gnt = gnt; err_csn = cs_n;
    end
    if (gnt != 0 && cs_n) n_cs_bad++;
    if (!cs_n) n_cs_low++;
    if (gnt != 0 && prev_gnt == 0) begin
      gnt_seq[n_gnt & 15] = gnt;
      gnt_cyc[n_gnt & 15] = cyc_n - t0;
      n_gnt++;
    end
    prev_gnt = gnt;
    if (auto_drop) req = req & ~done;
    if (ack_d[0]) i0++;
    if (ack_d[1]) i1++;
    tx0 = b0[i0 & 7];
    tx1 = b1[i1 & 7];
    ack_d = tx_ack;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && !m_hang) begin
        spi_busy = 1'b0;
        spi_rx   = m_byte;
      end
    end
    if (spi_en_n == 1'b0) begin
      spi_busy = 1'b1;
      m_byte   = spi_tx;
      m_cnt    = 20;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=stuck expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b0; req = '0; len0 = '0; len1 = '0; tx0 = '0; tx1 = '0;
    spi_rx = '0; spi_busy = 1'b0; m_cnt = 0; m_hang = 1'b0; m_byte = '0;
    prev_gnt = '0; auto_drop = 1'b1;
    for (int k = 0; k < 8; k++) begin b0[k] = '0; b1[k] = '0; end
    clr();
    cyc(); cyc();

    // Reset values
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_en_n", spi_en_n, 1'b1);
    chk("rst_spi_tx", spi_tx, 8'h00);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_pulses", {tx_ack, rx_valid, done, err}, 8'h00);
    rst = 1'b1;
    cyc();

    // Single 3-byte burst from requester 0
    b0[0] = 8'hA5; b0[1] = 8'h3C; b0[2] = 8'h0F;
    len0 = 4'd2;
    clr();
    req = 2'b01;
    cyc();
    chk("t1_gnt_c1", gnt, 2'b01);
    chk("t1_csn_c1", cs_n, 1'b0);
    cyc();
    chk("t1_ack_c2", tx_ack, 2'b01);
    cyc();
    chk("t1_en_c3", spi_en_n, 1'b0);
    chk("t1_spitx_c3", spi_tx, 8'hA5);
    for (int k = 0; k < 200 && n_done == 0; k++) cyc();
    chk("t1_done_cyc", done_cyc, 75);
    chk("t1_done_who", done_who, 2'b01);
    chk("t1_done_gnt", done_gnt, 2'b00);
    chk("t1_done_csn", done_csn, 1'b1);
    chk("t1_n_ack", n_ack, 3);
    chk("t1_n_rxv", n_rxv, 3);
    chk("t1_rx0", rx_log[0], 8'hA5);
    chk("t1_rx1", rx_log[1], 8'h3C);
    chk("t1_rx2", rx_log[2], 8'h0F);
    chk("t1_rxv_who", {rxv_who[0], rxv_who[1], rxv_who[2]}, 6'b010101);
    chk("t1_cs_low", n_cs_low, 74);
    chk("t1_cs_bad", n_cs_bad, 0);
    cyc();
    chk("t1_gnt_idle", gnt, 2'b00);

    // Contention straight after reset: requester 0 first, then 1
    rst = 1'b0; cyc(); rst = 1'b1;
    b0[0] = 8'h11; b1[0] = 8'h22; len0 = 4'd0; len1 = 4'd0;
    clr();
    req = 2'b11;
    for (int k = 0; k < 200 && n_done < 2; k++) cyc();
    chk("t2_n_gnt", n_gnt, 2);
    chk("t2_gnt0", gnt_seq[0], 2'b01);
    chk("t2_gnt1", gnt_seq[1], 2'b10);
    chk("t2_gnt0_cyc", gnt_cyc[0], 1);
    chk("t2_gnt1_cyc", gnt_cyc[1], 27);
    chk("t2_done2_cyc", done_cyc, 51);
    chk("t2_done2_who", done_who, 2'b10);
    chk("t2_rx", {rx_log[0], rx_log[1]}, 16'h1122);

    // Fairness with both requests held across six bursts
    auto_drop = 1'b0;
    clr();
    req = 2'b11;
    for (int k = 0; k < 400 && n_done < 6; k++) cyc();
    req = 2'b00;
    cyc(); cyc();
    chk("t3_n_done", n_done, 6);
    chk("t3_n_gnt", n_gnt, 6);
    chk("t3_seq", {gnt_seq[0], gnt_seq[1], gnt_seq[2], gnt_seq[3], gnt_seq[4], gnt_seq[5]},
        12'b01_10_01_10_01_10);
    chk("t3_onehot", n_multi, 0);

    // Request dropped after the first byte of a 4-byte burst
    auto_drop = 1'b1;
    b0[0] = 8'h01; b0[1] = 8'h02; b0[2] = 8'h03; b0[3] = 8'h04;
    len0 = 4'd3;
    clr();
    req = 2'b01;
    for (int k = 0; k < 100 && n_rxv == 0; k++) cyc();
    req = 2'b00;
    for (int k = 0; k < 200 && n_done == 0; k++) cyc();
    chk("t4_n_done", n_done, 1);
    chk("t4_done_who", done_who, 2'b01);
    chk("t4_n_rxv", n_rxv, 4);
    chk("t4_n_ack", n_ack, 4);
    chk("t4_rx3", rx_log[3], 8'h04);

    // Reset asserted while waiting for busy to fall
    len0 = 4'd0; b0[0] = 8'h77;
    clr();
    req = 2'b01;
    for (int k = 0; k < 10; k++) cyc();
    chk("t5_wait_csn", cs_n, 1'b0);
    rst = 1'b0;
    cyc();
    chk("t5_rst_csn", cs_n, 1'b1);
    chk("t5_rst_en", spi_en_n, 1'b1);
    chk("t5_rst_gnt", gnt, 2'b00);
    rst = 1'b1; req = 2'b00;
    for (int k = 0; k < 40; k++) cyc();
    chk("t5_no_done", n_done, 0);
    chk("t5_no_rxv", n_rxv, 0);
    chk("t5_no_err", n_errp, 0);

    // Master holds busy high
    b0[0] = 8'h5A;
    clr();
    m_hang = 1'b1;
    req = 2'b01;
`ifdef SPI_SCHED_TIMEOUT_EN
    for (int k = 0; k < 200 && n_errp == 0; k++) cyc();
    req = 2'b00;
    chk("t6_err_cyc", err_cyc, 68);
    chk("t6_err_who", err_who, 2'b01);
    chk("t6_err_gnt", err_gnt, 2'b00);
    chk("t6_err_csn", err_csn, 1'b1);
    m_hang = 1'b0; spi_busy = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    chk("t6_no_done", n_done, 0);
    chk("t6_no_rxv", n_rxv, 0);
    chk("t6_n_gnt", n_gnt, 1);
`else
    for (int k = 0; k < 150; k++) cyc();
    chk("t6_no_err", n_errp, 0);
    chk("t6_hold_csn", cs_n, 1'b0);
    chk("t6_hold_gnt", gnt, 2'b01);
    chk("t6_hold_rxv", n_rxv, 0);
    m_hang = 1'b0; spi_busy = 1'b0; spi_rx = m_byte;
    for (int k = 0; k < 20 && n_done == 0; k++) cyc();
    chk("t6_done", n_done, 1);
    chk("t6_rx", rx_log[0], 8'h5A);
`endif
    cyc();
    chk("final_onehot", n_multi, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_txn_scheduler.md
# spi_txn_scheduler

- Shares the byte-level SPI master between two requesters and sequences their multi-byte transactions.
- Each transaction runs as one framed burst: round-robin arbitration, per-byte start and handshake with the master, and its own chip-select held across all bytes of the burst.
- Sits between the system-side clients and the SPI master, and is the only block allowed to drive the master's start and data inputs.

## Interface
Parameters:
- LEN_W, 4, width of the length fields; a burst is len+1 bytes (1..16 at default).
- CS_GAP, 2, idle cycles between the end of one byte and the next start, with cs_n held low; legal range 1..15.
- TIMEOUT_CYC, 4096, busy watchdog limit in sclk cycles; used only when SPI_SCHED_TIMEOUT_EN is defined.

Ports:
- sclk  in  1  block clock.
- rst  in  1  reset, synchronous, active-low.
- req  in  2  per-requester level request; held until that requester's done pulse.
- len0, len1  in  LEN_W  burst length minus one; sampled at grant.
- tx0, tx1  in  8  next byte to send; sampled on that requester's tx_ack cycle.
- tx_ack  out  2  one-cycle pulse; the requester's byte was consumed, and the requester presents the next byte by the following cycle.
- rx_data  out  8  last received byte.
- rx_valid  out  2  one-hot, one-cycle pulse qualifying rx_data for the granted requester.
- done  out  2  one-cycle pulse at burst end.
- err  out  2  one-cycle pulse on watchdog abort; tied to 0 when the timeout feature is compiled out.
- gnt  out  2  one-hot grant; 0 when idle.
- cs_n  out  1  burst-level chip select, active low.
- spi_en_n  out  1  master start, active low, one cycle wide.
- spi_tx  out  8  byte to the master.
- spi_rx  in  8  byte from the master.
- spi_busy  in  1  master busy flag.

## Operation
- States: IDLE, GRANT, LOAD, START, WAIT_HI, WAIT_LO, CAPTURE, GAP, FINISH.
- IDLE: if any req bit is high, arbitrate and go to GRANT.
  - Round-robin pointer `last` resets to 1, so requester 0 wins the first contention.
  - When both request, the requester not named by `last` wins.
- GRANT: set gnt, latch len into a remaining-byte counter `rem`, drive cs_n low, update `last`.
- LOAD: drive spi_tx from the granted tx input and pulse tx_ack for the granted requester.
- START: spi_en_n low for exactly one cycle.
- WAIT_HI: wait for spi_busy=1.
- WAIT_LO: wait for spi_busy=0. Byte completion is a busy 1→0 transition; a busy that stays low is never taken as completion.
- CAPTURE: register spi_rx into rx_data and pulse rx_valid for the granted requester.
  - If rem=0, go to FINISH.
  - Otherwise decrement rem and go to GAP.
- GAP: count CS_GAP cycles with cs_n low, then go to LOAD.
- FINISH: cs_n high, pulse done, clear gnt, go to IDLE.
- Dropping req mid-burst has no effect; the burst completes with all len+1 bytes and done still pulses.
- A requester still requesting after done is eligible again from IDLE. If the other requester is pending, the other requester wins.

## Timing
- Reset values, one edge after rst=0 is sampled: gnt=0, cs_n=1, spi_en_n=1, spi_tx=0, tx_ack=0, rx_valid=0, rx_data=0, done=0, err=0, rem=0, `last`=1, state IDLE.
- Reset mid-burst aborts immediately. No done or err pulse is issued, and cs_n and spi_en_n are high after that edge.
- From req rising in IDLE (cycle 0):
  - gnt and cs_n=0 at cycle 1, tx_ack at cycle 2, spi_en_n=0 at cycle 3.
- After the busy falling edge is seen, rx_valid pulses on the next cycle.
- Done pulses one cycle after the last rx_valid; gnt is 0 and cs_n is 1 on that same cycle.
- Gap between byte starts within a burst: busy-low detection + 1 (CAPTURE) + CS_GAP + 1 (LOAD) cycles, then START.
- At most one bit of each of tx_ack, rx_valid, done and err is high in any cycle, and they never coincide for different requesters.

## Configuration
- SPI_SCHED_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to WAIT_HI and counts while in WAIT_HI or WAIT_LO.
  - Reaching TIMEOUT_CYC pulses err for the granted requester and forces cs_n=1, gnt=0 and a return to IDLE. No done pulse and no further rx_valid are issued.
  - spi_en_n stays high.
- SPI_SCHED_TIMEOUT_EN not defined: no counter, err tied to 0, and the block waits indefinitely on spi_busy.

## Test plan
- Single request: req=01, len0=2, tx0=A5,3C,0F, master model echoes after 20 cycles → three tx_ack[0], three rx_valid=01 with the echoed bytes, cs_n low for the whole burst, one done=01, gnt back to 00.
- Contention from reset: req=11, len0=len1=0 → gnt=01 first, then gnt=10; second burst starts CS_GAP-independent, one IDLE cycle after the first done.
- Fairness: req=11 held high for 6 bursts → grants alternate 01,10,01,10,01,10.
- Mid-burst effects:
  - req0 dropped after the first byte with len0=3 → all 4 bytes are still transferred and done=01 pulses.
  - rst=0 during WAIT_LO → next edge shows cs_n=1, spi_en_n=1, gnt=00, and no done pulse.
- Timeout (SPI_SCHED_TIMEOUT_EN defined, TIMEOUT_CYC=64): master holds busy=1 → err=01 at cycle 64 of the wait, cs_n=1, no done. With the macro undefined the bench sees no err and the block stays in WAIT_LO.
